display_scan_ctrl: RTL and testbench

Drives the 4-digit 7-segment scan on the board.
- Generates the one-hot digit select that feeds the nibble selector, and the matching active-low anode lines.
- Snapshots the 16-bit display value once per scan frame so all four digits of a frame show one coherent value.
- Applies a per-digit enable mask and optional leading-zero blanking.
- Sits between game/score logic (value source) and the nibble selector / hex-to-segment decoder.

---
 rtl/display_scan_ctrl.sv | 80 ++++++++
 tb/tb_display_scan_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller: one-hot digit ring, per-frame value
// snapshot, digit enable mask and optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int DIV      = 100000,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] N,
  input  logic [3:0]  dig_en,
  output logic [3:0]  sel,
  output logic [3:0]  an,
  output logic [3:0]  H,
  output logic        frame_start
);

  localparam int CW = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

  logic [CW-1:0] presc_reg;
  logic [3:0]    sel_reg;
  logic [15:0]   snap_val_reg;
  logic [3:0]    snap_en_reg;
  logic          frame_start_reg;
  logic          step;
  logic [3:0]    lz;
  logic [3:0]    vis;
  logic [3:0]    nib_masked [4];

  assign step = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg       <= '0;
      sel_reg         <= 4'b0001;
      snap_val_reg    <= 16'h0000;
      snap_en_reg     <= 4'b0000;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      if (step) begin
        presc_reg <= '0;
        sel_reg   <= {sel_reg[2:0], sel_reg[3]};
        // Leaving digit 3 closes the frame: latch a coherent value for the next one.
        if (sel_reg[3]) begin
          snap_val_reg    <= N;
          snap_en_reg     <= dig_en;
          frame_start_reg <= 1'b1;
        end
      end else begin
        presc_reg <= presc_reg + CW'(1);
      end
    end
  end

  // Blanking chains down from the top digit; digit 0 always shows.
  assign lz[3] = (LZ_BLANK != 0) && (snap_val_reg[15:12] == 4'h0);
  assign lz[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_lz
      assign lz[gi] = lz[gi+1] & (snap_val_reg[4*gi +: 4] == 4'h0);
    end
  endgenerate

  assign vis = snap_en_reg & ~lz;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign an[gi]         = ~(sel_reg[gi] & vis[gi]);
      assign nib_masked[gi] = {4{sel_reg[gi]}} & snap_val_reg[4*gi +: 4];
    end
  endgenerate

  // sel is one-hot, so an OR of masked nibbles is a glitch-free mux.
  assign H           = nib_masked[0] | nib_masked[1] | nib_masked[2] | nib_masked[3];
  assign sel         = sel_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: DIV=4 and DIV=1 with blanking,
// DIV=4 without blanking, all sharing one clock and stimulus.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] N;
  logic [3:0]  dig_en;

  logic [3:0] sel4, an4, h4;
  logic       fs4;
  logic [3:0] sel1, an1, h1;
  logic       fs1;
  logic [3:0] seln, ann, hn;
  logic       fsn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIV(4), .LZ_BLANK(1)) dut4 (
    .clk(clk), .reset(reset), .N(N), .dig_en(dig_en),
    .sel(sel4), .an(an4), .H(h4), .frame_start(fs4)
  );

  display_scan_ctrl #(.DIV(1), .LZ_BLANK(1)) dut1 (
    .clk(clk), .reset(reset), .N(N), .dig_en(dig_en),
    .sel(sel1), .an(an1), .H(h1), .frame_start(fs1)
  );

  display_scan_ctrl #(.DIV(4), .LZ_BLANK(0)) dutn (
    .clk(clk), .reset(reset), .N(N), .dig_en(dig_en),
    .sel(seln), .an(ann), .H(hn), .frame_start(fsn)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first cycle of a frame; checks all 16 cycles of it and
  // applies the next frame's inputs two cycles in.
  task automatic check_frame(input logic [15:0] val, input logic [3:0] vis4,
                             input logic [3:0] visn, input logic [15:0] next_n,
                             input logic [3:0] next_en);
    logic [3:0] s;
    $display("frame val=%h vis4=%b visn=%b next=%h/%b", val, vis4, visn, next_n, next_en);
    for (int k = 0; k < 16; k++) begin
      s = 4'b0001 << (k / 4);
      chk("frm_sel", {12'h0, sel4}, {12'h0, s});
      chk("frm_fs", {15'h0, fs4}, {15'h0, (k == 0)});
      chk("frm_h", {12'h0, h4}, {12'h0, val[4*(k/4) +: 4]});
      chk("frm_an", {12'h0, an4}, {12'h0, ~(s & vis4)});
      chk("frm_an_nolz", {12'h0, ann}, {12'h0, ~(s & visn)});
      chk("frm_h_nolz", {12'h0, hn}, {12'h0, val[4*(k/4) +: 4]});
      if (k == 2) begin
        N      = next_n;
        dig_en = next_en;
      end
      tick();
    end
  endtask

  initial begin
    reset  = 1'b1;
    N      = 16'h1234;
    dig_en = 4'b1111;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sel", {12'h0, sel4}, 16'h0001);
      chk("rst_an", {12'h0, an4}, 16'h000f);
      chk("rst_h", {12'h0, h4}, 16'h0000);
      chk("rst_fs", {15'h0, fs4}, 16'h0000);
      chk("rst_sel1", {12'h0, sel1}, 16'h0001);
    end
    reset = 1'b0;
    $display("reset released");

    // Blank first frame plus rotation timing for DIV=4 and DIV=1.
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("rot_sel4", {12'h0, sel4}, {12'h0, 4'b0001 << ((t / 4) % 4)});
      chk("rot_fs4", {15'h0, fs4}, {15'h0, (t == 16)});
      chk("rot_sel1", {12'h0, sel1}, {12'h0, 4'b0001 << (t % 4)});
      chk("rot_fs1", {15'h0, fs1}, {15'h0, (t % 4 == 0)});
      if (t < 16) begin
        chk("blank_an4", {12'h0, an4}, 16'h000f);
        chk("blank_h4", {12'h0, h4}, 16'h0000);
      end
    end

    check_frame(16'h1234, 4'b1111, 4'b1111, 16'hABCD, 4'b1111);
    check_frame(16'hABCD, 4'b1111, 4'b1111, 16'h1111, 4'b1111);
    check_frame(16'h1111, 4'b1111, 4'b1111, 16'h0042, 4'b1111);
    check_frame(16'h0042, 4'b0011, 4'b1111, 16'h0000, 4'b1111);
    check_frame(16'h0000, 4'b0001, 4'b1111, 16'h1005, 4'b1111);
    check_frame(16'h1005, 4'b1111, 4'b1111, 16'h9876, 4'b0101);
    check_frame(16'h9876, 4'b0101, 4'b0101, 16'h0100, 4'b1011);
    check_frame(16'h0100, 4'b0011, 4'b1011, 16'h5A5A, 4'b1111);

    // Mid-frame reset while digit 2 is showing.
    for (int i = 0; i < 8; i++) tick();
    chk("mid_sel", {12'h0, sel4}, 16'h0004);
    chk("mid_h", {12'h0, h4}, 16'h000a);
    reset = 1'b1;
    tick();
    $display("mid-frame reset");
    chk("midrst_sel", {12'h0, sel4}, 16'h0001);
    chk("midrst_an", {12'h0, an4}, 16'h000f);
    chk("midrst_h", {12'h0, h4}, 16'h0000);
    chk("midrst_fs", {15'h0, fs4}, 16'h0000);
    reset  = 1'b0;
    N      = 16'h0007;
    dig_en = 4'b1111;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("post_sel", {12'h0, sel4}, {12'h0, 4'b0001 << ((t / 4) % 4)});
      chk("post_fs", {15'h0, fs4}, {15'h0, (t == 16)});
      if (t < 16) chk("post_an", {12'h0, an4}, 16'h000f);
    end
    check_frame(16'h0007, 4'b0001, 4'b1111, 16'h0000, 4'b0000);

    // Reset landing exactly on a frame boundary wins over the snapshot.
    for (int i = 0; i < 15; i++) tick();
    chk("pre_bnd_sel", {12'h0, sel4}, 16'h0008);
    reset = 1'b1;
    tick();
    $display("boundary reset");
    chk("bnd_fs", {15'h0, fs4}, 16'h0000);
    chk("bnd_sel", {12'h0, sel4}, 16'h0001);
    chk("bnd_an", {12'h0, an4}, 16'h000f);
    chk("bnd_h", {12'h0, h4}, 16'h0000);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
